hadamard_frame_ctrl: RTL and testbench

Initiator and sequencer for the 4-lane complex Hadamard butterfly core. It buffers one frame of SFP samples and issues the frame to the core one 4-sample group at a time, driving start, data and twiddle buses. It collects each group's result on the core's done pulse, then streams the processed frame out. It sits between the sample source and the downstream FFT stage, and owns the core's start/done handshake.

---
 rtl/hadamard_frame_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_hadamard_frame_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hadamard_frame_ctrl.sv
// Frame sequencer for the 4-lane complex Hadamard butterfly core: buffers one
// frame, issues it group by group over a start/done handshake, then streams it out.
module hadamard_frame_ctrl #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9,
  parameter int NGROUP      = 4,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [formatWidth-1:0]     in_real,
  input  logic [formatWidth-1:0]     in_imag,
  input  logic                       tw_we,
  input  logic [ADDR_W-1:0]          tw_addr,
  input  logic [formatWidth-1:0]     tw_real,
  input  logic [formatWidth-1:0]     tw_imag,
  output logic                       core_start,
  output logic [4*formatWidth-1:0]   core_in_real,
  output logic [4*formatWidth-1:0]   core_in_imag,
  output logic [4*formatWidth-1:0]   core_tw_real,
  output logic [4*formatWidth-1:0]   core_tw_imag,
  input  logic [4*formatWidth-1:0]   core_out_real,
  input  logic [4*formatWidth-1:0]   core_out_imag,
  input  logic                       core_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [formatWidth-1:0]     out_real,
  output logic [formatWidth-1:0]     out_imag,
  output logic                       out_last,
  output logic                       err_timeout
);

  localparam int unsigned FW = formatWidth;
  localparam int unsigned NS = 4 * NGROUP;
  localparam int unsigned GW = ADDR_W - 2;
  localparam int unsigned TW = $clog2(TIMEOUT + 2);

  if ((formatWidth != 1 + expWidth + sigWidth) || ((1 << ADDR_W) != 4 * NGROUP)) begin : g_param_check
    $error("hadamard_frame_ctrl: inconsistent parameter set");
  end

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-1:0]     r_k;
  logic [GW-1:0]         r_g;
  logic [GW-1:0]         w_issue_g;
  logic [ADDR_W-1:0]     r_idx;
  logic [TW-1:0]         r_timer;
  logic                  r_err;
  logic                  r_core_start;
  logic [4*FW-1:0]       r_core_in_re;
  logic [4*FW-1:0]       r_core_in_im;
  logic [4*FW-1:0]       r_core_tw_re;
  logic [4*FW-1:0]       r_core_tw_im;

  logic [FW-1:0]         r_buf_re [NS];
  logic [FW-1:0]         r_buf_im [NS];
  logic [FW-1:0]         r_tw_re  [NS];
  logic [FW-1:0]         r_tw_im  [NS];
  logic [FW-1:0]         r_res_re [NS];
  logic [FW-1:0]         r_res_im [NS];

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_k_last;
  logic                  w_g_last;
  logic                  w_idx_last;
  logic                  w_timeout;
  logic                  w_capture;

  always_comb begin
    w_in_fire  = in_valid && (r_state == S_LOAD);
    w_out_fire = out_ready && (r_state == S_DRAIN);
    w_k_last   = (r_k == ADDR_W'(NS - 1));
    w_g_last   = (r_g == GW'(NGROUP - 1));
    w_idx_last = (r_idx == ADDR_W'(NS - 1));
    w_timeout  = (r_timer == TW'(TIMEOUT));
    w_capture  = core_done && (r_state == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // A done arriving on the timeout cycle still counts: it is tested first.
  always_comb begin
    w_next    = r_state;
    w_issue_g = '0;
    case (r_state)
      S_LOAD: begin
        if (w_in_fire && w_k_last) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (w_g_last) begin
            w_next = S_DRAIN;
          end else begin
            w_next    = S_ISSUE;
            w_issue_g = r_g + GW'(1);
          end
        end else if (w_timeout) begin
          w_next = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (w_out_fire && w_idx_last) begin
          w_next = S_LOAD;
        end
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  // Core buses are loaded on the edge that enters ISSUE, so they are valid
  // alongside core_start; the timer reads 0 in ISSUE and counts cycles since start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k          <= '0;
      r_g          <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
      r_core_in_re <= '0;
      r_core_in_im <= '0;
      r_core_tw_re <= '0;
      r_core_tw_im <= '0;
    end else begin
      r_core_start <= (w_next == S_ISSUE);

      if (r_state == S_WAIT && !core_done && w_timeout) begin
        r_k <= '0;
      end else if (w_in_fire) begin
        r_k <= r_k + ADDR_W'(1);
      end

      if (w_next == S_WAIT) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= '0;
      end

      if (r_state == S_WAIT && !core_done && w_timeout) begin
        r_err <= 1'b1;
      end

      if (r_state == S_WAIT) begin
        r_idx <= '0;
      end else if (w_out_fire) begin
        r_idx <= r_idx + ADDR_W'(1);
      end

      if (w_next == S_ISSUE) begin
        r_g <= w_issue_g;
        for (int unsigned j = 0; j < 4; j++) begin
          r_core_in_re[j*FW +: FW] <= r_buf_re[{w_issue_g, 2'(j)}];
          r_core_in_im[j*FW +: FW] <= r_buf_im[{w_issue_g, 2'(j)}];
          r_core_tw_re[j*FW +: FW] <= r_tw_re[{w_issue_g, 2'(j)}];
          r_core_tw_im[j*FW +: FW] <= r_tw_im[{w_issue_g, 2'(j)}];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf_re[r_k] <= in_real;
      r_buf_im[r_k] <= in_imag;
    end
    if (tw_we) begin
      r_tw_re[tw_addr] <= tw_real;
      r_tw_im[tw_addr] <= tw_imag;
    end
    if (w_capture) begin
      for (int unsigned j = 0; j < 4; j++) begin
        r_res_re[{r_g, 2'(j)}] <= core_out_real[j*FW +: FW];
        r_res_im[{r_g, 2'(j)}] <= core_out_imag[j*FW +: FW];
      end
    end
  end

  always_comb begin
    in_ready     = (r_state == S_LOAD);
    out_valid    = (r_state == S_DRAIN);
    out_last     = (r_state == S_DRAIN) && w_idx_last;
    out_real     = r_res_re[r_idx];
    out_imag     = r_res_im[r_idx];
    err_timeout  = r_err;
    core_start   = r_core_start;
    core_in_real = r_core_in_re;
    core_in_imag = r_core_in_im;
    core_tw_real = r_core_tw_re;
    core_tw_imag = r_core_tw_im;
  end

endmodule

// File: tb/tb_hadamard_frame_ctrl.sv
// Bench for hadamard_frame_ctrl: a behavioural core stand-in plus a frame-level
// reference model (expected output = sample XOR 1FF, buses = model arrays).
module tb_hadamard_frame_ctrl;
  localparam int FW = 9;
  localparam int NG = 4;
  localparam int NS = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [8:0] in_real = '0, in_imag = '0;
  logic tw_we = 1'b0;
  logic [3:0] tw_addr = '0;
  logic [8:0] tw_real = '0, tw_imag = '0;
  logic core_start, core_done;
  logic [35:0] core_in_real, core_in_imag, core_tw_real, core_tw_imag;
  logic [35:0] core_out_real = '0, core_out_imag = '0;
  logic out_valid, out_ready = 1'b0, out_last, err_timeout;
  logic [8:0] out_real, out_imag;

  hadamard_frame_ctrl #(.expWidth(4), .sigWidth(4), .formatWidth(FW), .NGROUP(NG),
                        .ADDR_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .tw_we(tw_we), .tw_addr(tw_addr),
    .tw_real(tw_real), .tw_imag(tw_imag), .core_start(core_start),
    .core_in_real(core_in_real), .core_in_imag(core_in_imag),
    .core_tw_real(core_tw_real), .core_tw_imag(core_tw_imag),
    .core_out_real(core_out_real), .core_out_imag(core_out_imag),
    .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_last(out_last),
    .err_timeout(err_timeout));

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Core stand-in: done 3 cycles after start, result = input XOR 1FF per lane.
  logic model_done = 1'b0, spur_done = 1'b0;
  assign core_done = model_done | spur_done;
  int n_starts = 0, drop_at = -1, pend_d = 0;
  logic [35:0] held_re, held_im;
  logic [35:0] cap_in_re[$], cap_in_im[$], cap_tw_re[$], cap_tw_im[$];
  int cap_cyc[$];

  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst) begin
      pend_d = 0;
    end else begin
      if (pend_d > 0) begin
        pend_d--;
        if (pend_d == 0) begin
          model_done    = 1'b1;
          core_out_real = held_re ^ {4{9'h1FF}};
          core_out_imag = held_im ^ {4{9'h1FF}};
        end
      end
      if (core_start) begin
        cap_in_re.push_back(core_in_real);
        cap_in_im.push_back(core_in_imag);
        cap_tw_re.push_back(core_tw_real);
        cap_tw_im.push_back(core_tw_imag);
        cap_cyc.push_back(cyc);
        if (n_starts != drop_at) begin
          pend_d  = 3;
          held_re = core_in_real;
          held_im = core_in_imag;
        end
        n_starts++;
      end
    end
  end

  // Reference model state
  logic [8:0] fr_re[NS], fr_im[NS], tw_m_re[NS], tw_m_im[NS];
  logic [8:0] got_re[NS], got_im[NS];
  logic       got_last[NS];

  function automatic logic [35:0] grp(input int g, input int which);
    logic [35:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      case (which)
        0:       v[j*9 +: 9] = fr_re[4*g+j];
        1:       v[j*9 +: 9] = fr_im[4*g+j];
        2:       v[j*9 +: 9] = tw_m_re[4*g+j];
        default: v[j*9 +: 9] = tw_m_im[4*g+j];
      endcase
    end
    return v;
  endfunction

  task automatic write_tw(input int a, input logic [8:0] re, input logic [8:0] im);
    @(negedge clk);
    tw_we = 1'b1; tw_addr = 4'(a); tw_real = re; tw_imag = im;
    tw_m_re[a] = re; tw_m_im[a] = im;
    @(negedge clk);
    tw_we = 1'b0;
  endtask

  task automatic gen_frame();
    for (int i = 0; i < NS; i++) begin
      fr_re[i] = 9'($urandom_range(0, 511));
      fr_im[i] = 9'($urandom_range(0, 511));
    end
  endtask

  task automatic load_frame(input bit gaps, output bit to);
    int i, guard;
    i = 0; guard = 0; to = 1'b0;
    while (i < NS && !to) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1; in_real = fr_re[i]; in_imag = fr_im[i];
      end
      if (in_valid && in_ready) i++;
      guard++;
      if (guard > 200) to = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: repeating 1,0,0,1, 2: random
  task automatic drain_collect(input int mode, output int nx, output int holds_bad,
                               output int seen_valid_cycles);
    logic pv, pr, pl;
    logic [8:0] pre, pim;
    int vc;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pre = '0; pim = '0;
    nx = 0; holds_bad = 0; vc = 0;
    for (int c = 0; c < 300 && nx < NS; c++) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (vc % 4 == 0) || (vc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (pv && !pr && (!out_valid || out_real !== pre || out_imag !== pim || out_last !== pl))
        holds_bad++;
      if (out_valid && out_ready) begin
        got_re[nx] = out_real; got_im[nx] = out_imag; got_last[nx] = out_last;
        nx++;
      end
      if (out_valid) vc++;
      pv = out_valid; pr = out_ready; pre = out_real; pim = out_imag; pl = out_last;
    end
    seen_valid_cycles = vc;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_starts(input int target, output bit to);
    int guard;
    guard = 0; to = 1'b0;
    while (n_starts < target && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (n_starts < target) to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, core_start, err_timeout, out_last} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_flags got rdy/ov/st/err/last=%b want 10000",
               {in_ready, out_valid, core_start, err_timeout, out_last});
    end
    tests_run++;
    if ({core_in_real, core_in_imag, core_tw_real, core_tw_imag} !== '0) begin
      tests_failed++;
      $display("FAIL reset_buses got %h %h want 0", core_in_real, core_tw_real);
    end
    rst = 1'b1;
  endtask

  task automatic test_frame_pass();
    bit to; int base, nx, hb, vc;
    for (int i = 0; i < NS; i++) write_tw(i, 9'h080 + 9'(i), 9'h0C0 + 9'(i));
    for (int i = 0; i < NS; i++) begin fr_re[i] = 9'(i); fr_im[i] = 9'h100 + 9'(i); end
    base = n_starts;
    load_frame(1'b0, to);
    drain_collect(0, nx, hb, vc);
    tests_run++;
    if (to || nx != NS || n_starts - base != 4) begin
      tests_failed++;
      $display("FAIL pass_counts got to=%0d xfers=%0d starts=%0d want 0/16/4", to, nx, n_starts - base);
    end else begin
      for (int g = 1; g < 4; g++) begin
        tests_run++;
        if (cap_cyc[base+g] - cap_cyc[base+g-1] != 4) begin
          tests_failed++;
          $display("FAIL pass_start_spacing g%0d got %0d want 4", g, cap_cyc[base+g] - cap_cyc[base+g-1]);
        end
      end
      tests_run++;
      if (cap_in_re[base+1] !== {9'd7, 9'd6, 9'd5, 9'd4} ||
          cap_tw_re[base+1] !== {9'h087, 9'h086, 9'h085, 9'h084}) begin
        tests_failed++;
        $display("FAIL pass_group1_bus got in=%h tw=%h", cap_in_re[base+1], cap_tw_re[base+1]);
      end
      for (int i = 0; i < NS; i++) begin
        tests_run++;
        if ({got_re[i], got_im[i], got_last[i]} !== {fr_re[i] ^ 9'h1FF, fr_im[i] ^ 9'h1FF, i == NS-1}) begin
          tests_failed++;
          $display("FAIL pass_out[%0d] got %h/%h/%b want %h/%h/%b", i, got_re[i], got_im[i],
                   got_last[i], fr_re[i] ^ 9'h1FF, fr_im[i] ^ 9'h1FF, i == NS-1);
        end
      end
    end
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_back_to_load got ov=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    bit to; int nx, hb, vc;
    gen_frame();
    load_frame(1'b0, to);
    drain_collect(1, nx, hb, vc);
    tests_run++;
    if (to || nx != NS || hb != 0) begin
      tests_failed++;
      $display("FAIL bp_transfers got to=%0d xfers=%0d hold_violations=%0d want 0/16/0", to, nx, hb);
    end
    for (int i = 0; i < NS; i++) begin
      tests_run++;
      if ({got_re[i], got_im[i], got_last[i]} !== {fr_re[i] ^ 9'h1FF, fr_im[i] ^ 9'h1FF, i == NS-1}) begin
        tests_failed++;
        $display("FAIL bp_out[%0d] got %h/%h want %h/%h", i, got_re[i], got_im[i],
                 fr_re[i] ^ 9'h1FF, fr_im[i] ^ 9'h1FF);
      end
    end
  endtask

  task automatic test_random_frames();
    bit to; int base, nx, hb, vc, errs;
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 3; w++)
        write_tw($urandom_range(0, NS-1), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
      gen_frame();
      base = n_starts;
      load_frame(1'b1, to);
      drain_collect(2, nx, hb, vc);
      tests_run++;
      if (to || nx != NS || hb != 0 || n_starts - base != 4) begin
        tests_failed++;
        $display("FAIL rand%0d_flow got to=%0d xfers=%0d holds=%0d starts=%0d", f, to, nx, hb, n_starts - base);
      end else begin
        errs = 0;
        for (int g = 0; g < 4; g++)
          if (cap_in_re[base+g] !== grp(g, 0) || cap_in_im[base+g] !== grp(g, 1) ||
              cap_tw_re[base+g] !== grp(g, 2) || cap_tw_im[base+g] !== grp(g, 3)) errs++;
        tests_run++;
        if (errs != 0) begin
          tests_failed++;
          $display("FAIL rand%0d_core_buses got %0d bad groups want 0", f, errs);
        end
        errs = 0;
        for (int i = 0; i < NS; i++)
          if ({got_re[i], got_im[i], got_last[i]} !== {fr_re[i] ^ 9'h1FF, fr_im[i] ^ 9'h1FF, i == NS-1})
            errs++;
        tests_run++;
        if (errs != 0) begin
          tests_failed++;
          $display("FAIL rand%0d_outputs got %0d bad samples want 0", f, errs);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit to; int base, nx, hb, vc, first_n; bit saw_valid;
    gen_frame();
    base = n_starts;
    drop_at = base + 2;
    load_frame(1'b0, to);
    wait_starts(base + 3, to);
    first_n = -1; saw_valid = 1'b0;
    tests_run++;
    if (to || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_reach_group2 got to=%0d err=%b want 0/0", to, err_timeout);
    end
    for (int n = 1; n <= 40 && first_n < 0; n++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
      if (err_timeout === 1'b1) first_n = n;
    end
    tests_run++;
    if (first_n != TO + 1) begin
      tests_failed++;
      $display("FAIL to_err_latency got %0d want %0d", first_n, TO + 1);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_back_to_load got in_ready=%b want 1", in_ready);
    end
    repeat (5) begin @(negedge clk); if (out_valid) saw_valid = 1'b1; end
    tests_run++;
    if (saw_valid) begin
      tests_failed++;
      $display("FAIL to_no_output got out_valid=1 want 0");
    end
    drop_at = -1;
    gen_frame();
    load_frame(1'b0, to);
    drain_collect(0, nx, hb, vc);
    tests_run++;
    if (to || nx != NS || err_timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_next_frame got to=%0d xfers=%0d err=%b want 0/16/1", to, nx, err_timeout);
    end
    for (int i = 0; i < NS; i++) begin
      tests_run++;
      if (got_re[i] !== (fr_re[i] ^ 9'h1FF)) begin
        tests_failed++;
        $display("FAIL to_next_out[%0d] got %h want %h", i, got_re[i], fr_re[i] ^ 9'h1FF);
      end
    end
  endtask

  task automatic test_spurious_and_race();
    bit to; int base, nx, hb, vc, bad; logic [35:0] snap; logic [8:0] old_re, new_re;
    snap = core_in_real; bad = 0;
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || core_start !== 1'b0 || in_ready !== 1'b1 || core_in_real !== snap) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL spurious_done got %0d disturbed cycles want 0", bad);
    end
    old_re = tw_m_re[4];
    new_re = old_re ^ 9'h155;
    gen_frame();
    base = n_starts;
    load_frame(1'b0, to);
    wait_starts(base + 2, to);
    tw_we = 1'b1; tw_addr = 4'd4; tw_real = new_re; tw_imag = tw_m_im[4];
    @(negedge clk);
    tw_we = 1'b0;
    drain_collect(0, nx, hb, vc);
    tests_run++;
    if (to || nx != NS || cap_tw_re[base+1][8:0] !== old_re) begin
      tests_failed++;
      $display("FAIL race_old_value got to=%0d xfers=%0d tw=%h want 0/16/%h", to, nx,
               cap_tw_re[base+1][8:0], old_re);
    end
    tw_m_re[4] = new_re;
    gen_frame();
    base = n_starts;
    load_frame(1'b0, to);
    drain_collect(0, nx, hb, vc);
    tests_run++;
    if (to || nx != NS || cap_tw_re[base+1] !== grp(1, 2)) begin
      tests_failed++;
      $display("FAIL race_new_value got to=%0d xfers=%0d tw=%h want %h", to, nx, cap_tw_re[base+1], grp(1, 2));
    end
  endtask

  task automatic test_reset_mid_wait();
    bit to; int base, nx, hb, vc, errs;
    gen_frame();
    base = n_starts;
    load_frame(1'b0, to);
    wait_starts(base + 2, to);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (to || {in_ready, out_valid, core_start, err_timeout} !== 4'b1000 ||
        core_in_real !== '0 || core_tw_real !== '0) begin
      tests_failed++;
      $display("FAIL midwait_reset got to=%0d rdy/ov/st/err=%b bus=%h want 0/1000/0", to,
               {in_ready, out_valid, core_start, err_timeout}, core_in_real);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    gen_frame();
    base = n_starts;
    load_frame(1'b1, to);
    drain_collect(2, nx, hb, vc);
    errs = 0;
    for (int i = 0; i < NS; i++)
      if ({got_re[i], got_im[i], got_last[i]} !== {fr_re[i] ^ 9'h1FF, fr_im[i] ^ 9'h1FF, i == NS-1}) errs++;
    tests_run++;
    if (to || nx != NS || errs != 0 || n_starts - base != 4) begin
      tests_failed++;
      $display("FAIL midwait_next_frame got to=%0d xfers=%0d bad=%0d starts=%0d", to, nx, errs, n_starts - base);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_pass();
    test_backpressure();
    test_random_frames();
    test_timeout();
    test_spurious_and_race();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
